// File: rtl/bus_cmd_master_pkg.sv
// bus_cmd_master_pkg: bus field positions and the master FSM state encoding.
// The command parser's model imports this package so both use the same encoding.
package bus_cmd_master_pkg;

    // bus_in fields (master -> slaves)
    localparam int unsigned BUS_FIELD_CLK     = 0;
    localparam int unsigned BUS_FIELD_RESET_L = 1;
    localparam int unsigned BUS_ADDR_START    = 2;
    localparam int unsigned BUS_ADDR_END      = 33;
    localparam int unsigned BUS_WR_DATA_START = 34;
    localparam int unsigned BUS_WR_DATA_END   = 65;
    localparam int unsigned BUS_FIELD_RE      = 66;
    localparam int unsigned BUS_FIELD_WE      = 67;
    localparam int unsigned BUS_IN_WIDTH      = 68;

    // bus_out fields (OR of all slaves -> master)
    localparam int unsigned BUS_RD_DATA_START = 0;
    localparam int unsigned BUS_RD_DATA_END   = 31;
    localparam int unsigned BUS_FIELD_RD_ACK  = 32;
    localparam int unsigned BUS_FIELD_WR_ACK  = 33;
    localparam int unsigned BUS_FIELD_IRQ     = 34;
    localparam int unsigned BUS_OUT_WIDTH     = 35;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } bus_cmd_state_e;

    // Bus addresses are word addresses in byte units; the low two bits never reach the bus.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: cycle counter for the bus_cmd_master ack timeout.
// clear zeroes the count, enable advances it, expired flags the TIMEOUT-th enabled cycle.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic bus_clk,
    input  logic bus_reset_l,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // expired is combinational so the FSM leaves WAIT at the end of the TIMEOUT-th cycle
    assign expired = enable && (count_q == LAST);

    // Count enabled cycles; hold once expired so the count never wraps.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/bus_cmd_master.sv
// bus_cmd_master: single-outstanding bus master. Takes read/write commands over
// valid/ready, drives bus_in, waits for the matching ack on bus_out and returns
// a response. Optional ack timeout under `define BUS_CMD_MASTER_TIMEOUT_EN.
module bus_cmd_master
    import bus_cmd_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     bus_clk,
    input  logic                     bus_reset_l,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [31:0]              cmd_addr,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic [BUS_IN_WIDTH-1:0]  bus_in,
    input  logic [BUS_OUT_WIDTH-1:0] bus_out
);

    bus_cmd_state_e state_q;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic           re_strobe_q;
    logic           we_strobe_q;
    logic           cmd_ready_q;
    logic           rsp_valid_q;
    logic [31:0]    rsp_rdata_q;

    logic        rd_ack;
    logic        wr_ack;
    logic        ack_match;
    logic [31:0] rd_data;
    logic        unused_irq;

    assign rd_ack     = bus_out[BUS_FIELD_RD_ACK];
    assign wr_ack     = bus_out[BUS_FIELD_WR_ACK];
    assign rd_data    = bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START];
    assign unused_irq = bus_out[BUS_FIELD_IRQ];
    // Only the ack that matches the outstanding command counts.
    assign ack_match  = we_q ? wr_ack : rd_ack;

`ifdef BUS_CMD_MASTER_TIMEOUT_EN
    logic wd_expired;
    logic err_q;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .clear       (state_q == S_ISSUE),
        .enable      (state_q == S_WAIT),
        .expired     (wd_expired)
    );

    assign rsp_err = err_q;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;

    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Command FSM with registered handshake outputs and bus strobes.
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            re_strobe_q <= 1'b0;
            we_strobe_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        we_q        <= cmd_we;
                        addr_q      <= word_align(cmd_addr);
                        wdata_q     <= cmd_wdata;
                        re_strobe_q <= !cmd_we;
                        we_strobe_q <= cmd_we;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Strobes are single-cycle pulses; addr/wr_data stay put through WAIT.
                    re_strobe_q <= 1'b0;
                    we_strobe_q <= 1'b0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (ack_match) begin
                        rsp_rdata_q <= we_q ? 32'h0 : rd_data;
                        rsp_valid_q <= 1'b1;
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                        state_q     <= S_RESP;
                    end
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
                    else if (wd_expired) begin
                        rsp_rdata_q <= 32'h0;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= S_RESP;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Pack the bus_in vector; clock and reset are forwarded to the slaves unchanged.
    always_comb begin
        bus_in                                    = '0;
        bus_in[BUS_FIELD_CLK]                     = bus_clk;
        bus_in[BUS_FIELD_RESET_L]                 = bus_reset_l;
        bus_in[BUS_ADDR_END:BUS_ADDR_START]       = addr_q;
        bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START] = wdata_q;
        bus_in[BUS_FIELD_RE]                      = re_strobe_q;
        bus_in[BUS_FIELD_WE]                      = we_strobe_q;
    end

endmodule

// File: tb/tb_bus_cmd_master.sv
// tb_bus_cmd_master: bus_cmd_master with a 4 KB ROM at 0x1000 (1-cycle ack),
// a 4-word register slave at 0x2000 (2-cycle ack) and injectable acks/irq.
module tb_bus_cmd_master;
    import bus_cmd_master_pkg::*;

    localparam int unsigned TIMEOUT = 8;

    logic                     bus_clk = 1'b0;
    logic                     bus_reset_l = 1'b0;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic                     cmd_we = 1'b0;
    logic [31:0]              cmd_addr = 32'h0;
    logic [31:0]              cmd_wdata = 32'h0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [31:0]              rsp_rdata;
    logic                     rsp_err;
    logic [BUS_IN_WIDTH-1:0]  bus_in;
    logic [BUS_OUT_WIDTH-1:0] bus_out;

    int n_vec = 0;
    int n_err = 0;

    bus_cmd_master #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bus_in      (bus_in),
        .bus_out     (bus_out)
    );

    always #5 bus_clk = ~bus_clk;

    // Decoded bus_in fields
    logic        b_re, b_we;
    logic [31:0] b_addr, b_wdata;
    assign b_re    = bus_in[BUS_FIELD_RE];
    assign b_we    = bus_in[BUS_FIELD_WE];
    assign b_addr  = bus_in[BUS_ADDR_END:BUS_ADDR_START];
    assign b_wdata = bus_in[BUS_WR_DATA_END:BUS_WR_DATA_START];

    function automatic logic [31:0] rom_word(input int unsigned idx);
        return 32'h1234_5678 ^ (idx * 32'h9E37_79B9);
    endfunction

    // ROM slave: registered read ack one cycle after re; never acks writes.
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        rom_hit;
    assign rom_hit = (b_addr[31:12] == 20'h00001);
    always @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            rom_ack  <= 1'b0;
            rom_data <= 32'h0;
        end else begin
            rom_ack  <= b_re && rom_hit;
            rom_data <= (b_re && rom_hit) ? rom_word(32'(b_addr[11:2])) : 32'h0;
        end
    end

    // Register slave: read and write acks two cycles after the strobe.
    logic [1:0]  rg_rd_p, rg_wr_p;
    logic [31:0] rg_mem [4];
    logic [31:0] rg_data_p1, rg_data_p2;
    logic        rg_hit;
    assign rg_hit = (b_addr[31:4] == 28'h0000200);
    always @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            rg_rd_p    <= 2'b00;
            rg_wr_p    <= 2'b00;
            rg_data_p1 <= 32'h0;
            rg_data_p2 <= 32'h0;
            for (int i = 0; i < 4; i++) rg_mem[i] <= 32'h0;
        end else begin
            rg_rd_p    <= {rg_rd_p[0], b_re && rg_hit};
            rg_wr_p    <= {rg_wr_p[0], b_we && rg_hit};
            if (b_we && rg_hit) rg_mem[b_addr[3:2]] <= b_wdata;
            if (b_re && rg_hit) rg_data_p1 <= rg_mem[b_addr[3:2]];
            rg_data_p2 <= rg_data_p1;
        end
    end

    // Directly driven acks/irq/data for mismatch tests
    logic        inj_rd_ack = 1'b0;
    logic        inj_wr_ack = 1'b0;
    logic        inj_irq    = 1'b0;
    logic [31:0] inj_data   = 32'h0;

    always_comb begin
        bus_out = '0;
        bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START] = (rom_ack ? rom_data : 32'h0)
                                                   | (rg_rd_p[1] ? rg_data_p2 : 32'h0)
                                                   | inj_data;
        bus_out[BUS_FIELD_RD_ACK] = rom_ack | rg_rd_p[1] | inj_rd_ack;
        bus_out[BUS_FIELD_WR_ACK] = rg_wr_p[1] | inj_wr_ack;
        bus_out[BUS_FIELD_IRQ]    = inj_irq;
    end

    // Strobe monitor, sampled mid-cycle
    int unsigned re_cycles = 0;
    int unsigned we_cycles = 0;
    int unsigned both_cycles = 0;
    always @(negedge bus_clk) begin
        if (b_re) re_cycles++;
        if (b_we) we_cycles++;
        if (b_re && b_we) both_cycles++;
    end

    logic [31:0] model_regs [4];

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench stalled");
    end

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic checkint(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check32({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check1({tag, "_rsp_err"}, rsp_err, 1'b0);
        check1({tag, "_re"}, b_re, 1'b0);
        check1({tag, "_we"}, b_we, 1'b0);
        check32({tag, "_addr"}, b_addr, 32'h0);
        check32({tag, "_wdata"}, b_wdata, 32'h0);
        check1({tag, "_fwd_reset_l"}, bus_in[BUS_FIELD_RESET_L], bus_reset_l);
    endtask

    // Present a command and let it be accepted; returns in the ISSUE cycle.
    task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check1("cmd_ready_before_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        check1("issue_re", b_re, !we);
        check1("issue_we", b_we, we);
        check32("issue_addr", b_addr, {addr[31:2], 2'b00});
        if (we) check32("issue_wdata", b_wdata, wdata);
        check1("issue_cmd_ready", cmd_ready, 1'b0);
        check1("issue_fwd_clk", bus_in[BUS_FIELD_CLK], bus_clk);
    endtask

    // Wait for rsp_valid, hold rsp_ready low for 'hold' cycles checking stability, then take it.
    task automatic await_rsp(input int limit, input int hold, output logic got,
                             output logic [31:0] rdata, output logic err, output int waited);
        logic [31:0] addr0;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < limit) begin
            tick();
            waited++;
        end
        got   = (rsp_valid === 1'b1);
        rdata = rsp_rdata;
        err   = rsp_err;
        addr0 = b_addr;
        if (got) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                check1("hold_rsp_valid", rsp_valid, 1'b1);
                check32("hold_rsp_rdata", rsp_rdata, rdata);
                check1("hold_rsp_err", rsp_err, err);
                check1("hold_cmd_ready", cmd_ready, 1'b0);
                check1("hold_no_strobe", b_re | b_we, 1'b0);
                check32("hold_addr", b_addr, addr0);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check1("after_rsp_valid", rsp_valid, 1'b0);
            check1("after_cmd_ready", cmd_ready, 1'b1);
        end
    endtask

    // Full transaction against an expected read value and latency (accept edge -> rsp_valid).
    task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int hold,
                           input logic [31:0] exp_rdata, input int exp_lat);
        logic        got, err;
        logic [31:0] rdata;
        int          waited;
        int unsigned re0, we0;
        re0 = re_cycles;
        we0 = we_cycles;
        issue_cmd(we, addr, wdata);
        await_rsp(exp_lat + 20, hold, got, rdata, err, waited);
        check1({tag, "_got"}, got, 1'b1);
        checkint({tag, "_lat"}, waited + 1, exp_lat);
        check32({tag, "_rdata"}, rdata, exp_rdata);
        check1({tag, "_err"}, err, 1'b0);
        checkint({tag, "_re_cycles"}, int'(re_cycles - re0), we ? 0 : 1);
        checkint({tag, "_we_cycles"}, int'(we_cycles - we0), we ? 1 : 0);
    endtask

    initial begin
        logic        got, err;
        logic [31:0] rdata;
        int          waited;

        for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;

        // Power-on reset
        repeat (3) tick();
        check_reset_outputs("por");
        @(negedge bus_clk);
        bus_reset_l = 1'b1;
        tick();

        // Latency = accept + ISSUE + slave ack latency; ROM acks after 1 cycle, registers after 2.
        run_txn("rom_read_1000", 1'b0, 32'h1000, 32'h0, 0, 32'h1234_5678, 3);
        run_txn("reg_write_2000", 1'b1, 32'h2000, 32'hA5A5_A5A5, 0, 32'h0, 4);
        model_regs[0] = 32'hA5A5_A5A5;
        run_txn("reg_read_2000", 1'b0, 32'h2000, 32'h0, 0, 32'hA5A5_A5A5, 4);
        run_txn("rom_read_1003", 1'b0, 32'h1003, 32'h0, 0, 32'h1234_5678, 3);
        run_txn("rsp_backpressure", 1'b0, 32'h1004, 32'h0, 20, rom_word(1), 3);

        // Randomized mix against the memory model
        for (int t = 0; t < 40; t++) begin
            int unsigned kind, idx;
            logic        we;
            logic [31:0] addr, wdata, exp_rdata;
            int          exp_lat;
            kind  = $urandom_range(0, 2);
            wdata = $urandom;
            if (kind == 0) begin
                idx       = $urandom_range(0, 1023);
                we        = 1'b0;
                addr      = 32'h1000 + idx * 4 + $urandom_range(0, 3);
                exp_rdata = rom_word(idx);
                exp_lat   = 2 + 1;
            end else begin
                idx     = $urandom_range(0, 3);
                we      = (kind == 1);
                addr    = 32'h2000 + idx * 4 + $urandom_range(0, 3);
                exp_lat = 2 + 2;
                if (we) begin
                    model_regs[idx] = wdata;
                    exp_rdata       = 32'h0;
                end else begin
                    exp_rdata = model_regs[idx];
                end
            end
            run_txn("rand", we, addr, wdata, $urandom_range(0, 3), exp_rdata, exp_lat);
        end

        // Read: wr_ack and irq must be ignored, the later rd_ack supplies the data.
        issue_cmd(1'b0, 32'h9000, 32'h0);
        tick();
        inj_wr_ack = 1'b1;
        inj_irq    = 1'b1;
        inj_data   = 32'hDEAD_BEEF;
        tick();
        tick();
        inj_wr_ack = 1'b0;
        inj_irq    = 1'b0;
        inj_data   = 32'h0;
        check1("mismatch_rd_no_rsp", rsp_valid, 1'b0);
        inj_rd_ack = 1'b1;
        inj_data   = 32'h0BAD_F00D;
        tick();
        inj_rd_ack = 1'b0;
        inj_data   = 32'h0;
        await_rsp(5, 1, got, rdata, err, waited);
        check1("inj_rd_got", got, 1'b1);
        checkint("inj_rd_lat", waited, 0);
        check32("inj_rd_rdata", rdata, 32'h0BAD_F00D);
        check1("inj_rd_err", err, 1'b0);

        // Write: rd_ack ignored, wr_ack completes with rdata 0.
        issue_cmd(1'b1, 32'h9004, 32'h1357_9BDF);
        tick();
        inj_rd_ack = 1'b1;
        inj_data   = 32'hFFFF_FFFF;
        tick();
        inj_rd_ack = 1'b0;
        inj_data   = 32'h0;
        check1("mismatch_wr_no_rsp", rsp_valid, 1'b0);
        inj_wr_ack = 1'b1;
        tick();
        inj_wr_ack = 1'b0;
        await_rsp(5, 0, got, rdata, err, waited);
        check1("inj_wr_got", got, 1'b1);
        checkint("inj_wr_lat", waited, 0);
        check32("inj_wr_rdata", rdata, 32'h0);
        check1("inj_wr_err", err, 1'b0);

        // Unmapped read
        issue_cmd(1'b0, 32'h9000, 32'h0);
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
        await_rsp(TIMEOUT + 10, 0, got, rdata, err, waited);
        check1("unmapped_got", got, 1'b1);
        checkint("unmapped_lat", waited + 1, TIMEOUT + 2);
        check32("unmapped_rdata", rdata, 32'h0);
        check1("unmapped_err", err, 1'b1);
        issue_cmd(1'b0, 32'h9000, 32'h0);
        repeat (3) tick();
`else
        await_rsp(100, 0, got, rdata, err, waited);
        check1("unmapped_no_rsp", got, 1'b0);
        check1("unmapped_cmd_ready", cmd_ready, 1'b0);
`endif

        // Reset mid-WAIT: outputs return to reset values without waiting for a clock edge.
        #2;
        bus_reset_l = 1'b0;
        #1;
        check_reset_outputs("mid_wait_reset");
        repeat (2) tick();
        @(negedge bus_clk);
        bus_reset_l = 1'b1;
        tick();
        run_txn("post_reset_rom_read", 1'b0, 32'h1000, 32'h0, 0, 32'h1234_5678, 3);

        // Write to the ROM: no wr_ack ever arrives.
        issue_cmd(1'b1, 32'h1000, 32'hFFFF_0000);
`ifdef BUS_CMD_MASTER_TIMEOUT_EN
        await_rsp(TIMEOUT + 10, 0, got, rdata, err, waited);
        check1("rom_write_got", got, 1'b1);
        checkint("rom_write_lat", waited + 1, TIMEOUT + 2);
        check32("rom_write_rdata", rdata, 32'h0);
        check1("rom_write_err", err, 1'b1);
`else
        await_rsp(30, 0, got, rdata, err, waited);
        check1("rom_write_no_rsp", got, 1'b0);
        check1("rom_write_cmd_ready", cmd_ready, 1'b0);
`endif

        checkint("never_re_and_we", int'(both_cycles), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
